// File: rtl/writeback_commit.sv
// Final pipeline stage: funnels up to two GPR writebacks per cycle onto the
// single regfile write port through a small FIFO with bypass, and holds the CR.
module writeback_commit #(
  parameter int regWidth     = 5,
  parameter int fifoDepth    = 4,
  parameter int countWidth   = 3,
  parameter int LdStUnitCode = 2
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic [2:0]            functionalUnitCode_i,
  input  logic                  reg1WritebackEnable_i,
  input  logic                  reg2WritebackEnable_i,
  input  logic [regWidth-1:0]   reg1WritebackAddress_i,
  input  logic [regWidth-1:0]   reg2WritebackAddress_i,
  input  logic [0:63]           reg1WritebackVal_i,
  input  logic [0:63]           reg2WritebackVal_i,
  input  logic                  condRegUpdateEnable_i,
  input  logic [32:63]          newCRVal_i,
  output logic                  stall_o,
  output logic                  gprWriteEnable_o,
  output logic [regWidth-1:0]   gprWriteAddress_o,
  output logic [0:63]           gprWriteVal_o,
  output logic [32:63]          condReg_o,
  output logic                  overflow_o,
  output logic [countWidth-1:0] fifoCount_o
);

  localparam int PTR_W = (fifoDepth > 1) ? $clog2(fifoDepth) : 1;
  localparam logic [countWidth-1:0] STALL_LEVEL = countWidth'(fifoDepth - 1);
  localparam logic [2:0] LDST_CODE = 3'(LdStUnitCode);

  typedef struct packed {
    logic [regWidth-1:0] addr;
    logic [0:63]         val;
  } gpr_write_t;

  gpr_write_t             fifo_mem [fifoDepth];
  logic [PTR_W-1:0]       rd_ptr;
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       wr_ptr_next_slot;
  logic [countWidth-1:0]  count;
  logic [countWidth-1:0]  count_next;

  logic                   w1;
  logic                   w2;
  logic                   any_write;
  logic                   both_write;
  logic                   accept;
  logic                   fifo_empty;
  logic                   bypass;
  logic                   dequeue;
  logic [1:0]             enq_cnt;
  gpr_write_t             write1;
  gpr_write_t             write2;
  gpr_write_t             first_write;
  gpr_write_t             enq_entry0;

  // Only the load/store unit's reg2 port carries GPR data; FX reg2 holds CR/flags.
  always_comb begin
    w1          = reg1WritebackEnable_i;
    w2          = reg2WritebackEnable_i && (functionalUnitCode_i == LDST_CODE);
    any_write   = w1 || w2;
    both_write  = w1 && w2;
    write1      = '{addr: reg1WritebackAddress_i, val: reg1WritebackVal_i};
    write2      = '{addr: reg2WritebackAddress_i, val: reg2WritebackVal_i};
    first_write = w1 ? write1 : write2;
  end

  assign stall_o     = (count >= STALL_LEVEL);
  assign fifoCount_o = count;

  // When the queue is empty the oldest accepted write skips the FIFO entirely.
  always_comb begin
    fifo_empty       = (count == '0);
    accept           = !stall_o && any_write;
    bypass           = fifo_empty && accept;
    dequeue          = !fifo_empty;
    wr_ptr_next_slot = wr_ptr + PTR_W'(1);
    enq_cnt          = 2'd0;
    enq_entry0       = first_write;
    if (accept) begin
      if (bypass) begin
        enq_cnt    = both_write ? 2'd1 : 2'd0;
        enq_entry0 = write2;
      end else begin
        enq_cnt    = both_write ? 2'd2 : 2'd1;
      end
    end
    count_next = count + countWidth'(enq_cnt) - countWidth'(dequeue);
  end

  always_ff @(posedge clock_i) begin
    if (enq_cnt != 2'd0) begin
      fifo_mem[wr_ptr] <= enq_entry0;
    end
    if (enq_cnt == 2'd2) begin
      fifo_mem[wr_ptr_next_slot] <= write2;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      count  <= count_next;
      rd_ptr <= rd_ptr + PTR_W'(dequeue);
      wr_ptr <= wr_ptr + PTR_W'(enq_cnt);
    end
  end

  // Address and data hold their last values when nothing is written.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      gprWriteEnable_o  <= 1'b0;
      gprWriteAddress_o <= '0;
      gprWriteVal_o     <= '0;
    end else if (dequeue) begin
      gprWriteEnable_o  <= 1'b1;
      gprWriteAddress_o <= fifo_mem[rd_ptr].addr;
      gprWriteVal_o     <= fifo_mem[rd_ptr].val;
    end else if (bypass) begin
      gprWriteEnable_o  <= 1'b1;
      gprWriteAddress_o <= first_write.addr;
      gprWriteVal_o     <= first_write.val;
    end else begin
      gprWriteEnable_o  <= 1'b0;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      condReg_o  <= '0;
      overflow_o <= 1'b0;
    end else begin
      overflow_o <= stall_o && any_write;
      if (condRegUpdateEnable_i) begin
        condReg_o <= newCRVal_i;
      end
    end
  end

endmodule

// File: tb/tb_writeback_commit.sv
// Directed-vector bench for writeback_commit: bypass, ordering, fill/stall,
// overflow drop and mid-drain reset.
module tb_writeback_commit;

  logic         clock_i = 1'b0;
  logic         reset_i;
  logic [2:0]   functionalUnitCode_i;
  logic         reg1WritebackEnable_i;
  logic         reg2WritebackEnable_i;
  logic [4:0]   reg1WritebackAddress_i;
  logic [4:0]   reg2WritebackAddress_i;
  logic [0:63]  reg1WritebackVal_i;
  logic [0:63]  reg2WritebackVal_i;
  logic         condRegUpdateEnable_i;
  logic [32:63] newCRVal_i;
  logic         stall_o;
  logic         gprWriteEnable_o;
  logic [4:0]   gprWriteAddress_o;
  logic [0:63]  gprWriteVal_o;
  logic [32:63] condReg_o;
  logic         overflow_o;
  logic [2:0]   fifoCount_o;

  int errors = 0;
  int checks = 0;

  writeback_commit #(
    .regWidth(5), .fifoDepth(4), .countWidth(3), .LdStUnitCode(2)
  ) dut (
    .clock_i(clock_i), .reset_i(reset_i),
    .functionalUnitCode_i(functionalUnitCode_i),
    .reg1WritebackEnable_i(reg1WritebackEnable_i),
    .reg2WritebackEnable_i(reg2WritebackEnable_i),
    .reg1WritebackAddress_i(reg1WritebackAddress_i),
    .reg2WritebackAddress_i(reg2WritebackAddress_i),
    .reg1WritebackVal_i(reg1WritebackVal_i),
    .reg2WritebackVal_i(reg2WritebackVal_i),
    .condRegUpdateEnable_i(condRegUpdateEnable_i),
    .newCRVal_i(newCRVal_i),
    .stall_o(stall_o),
    .gprWriteEnable_o(gprWriteEnable_o),
    .gprWriteAddress_o(gprWriteAddress_o),
    .gprWriteVal_o(gprWriteVal_o),
    .condReg_o(condReg_o),
    .overflow_o(overflow_o),
    .fifoCount_o(fifoCount_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic drive(input logic [2:0] fu,
                       input logic e1, input logic [4:0] a1, input logic [63:0] v1,
                       input logic e2, input logic [4:0] a2, input logic [63:0] v2,
                       input logic cre, input logic [31:0] cr);
    functionalUnitCode_i   = fu;
    reg1WritebackEnable_i  = e1;
    reg1WritebackAddress_i = a1;
    reg1WritebackVal_i     = v1;
    reg2WritebackEnable_i  = e2;
    reg2WritebackAddress_i = a2;
    reg2WritebackVal_i     = v2;
    condRegUpdateEnable_i  = cre;
    newCRVal_i             = cr;
  endtask

  task automatic idle();
    drive(3'd0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 32'd0);
  endtask

  // Advance one edge and settle so outputs reflect that edge.
  task automatic step();
    @(posedge clock_i);
    #1;
  endtask

  // Three LdSt dual-write cycles from empty; writes k: addr base+k, val vbase+k.
  task automatic fill_three(input logic [4:0] base, input logic [63:0] vbase);
    for (int k = 0; k < 3; k++) begin
      drive(3'd2, 1'b1, base + 5'(2*k), vbase + 64'(2*k),
                  1'b1, base + 5'(2*k+1), vbase + 64'(2*k+1), 1'b0, 32'd0);
      step();
    end
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    drive(3'd2, 1'b1, 5'd9, 64'hFFFF, 1'b1, 5'd10, 64'hEEEE, 1'b1, 32'hFFFF_FFFF);
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({gprWriteEnable_o, gprWriteAddress_o, gprWriteVal_o, condReg_o, overflow_o} !== '0) begin
        errors++;
        $display("[TB] FAIL reset_outputs: got we=%b addr=%0d val=%h cr=%h ovf=%b, expected all 0",
                 gprWriteEnable_o, gprWriteAddress_o, gprWriteVal_o, condReg_o, overflow_o);
      end
      checks++;
      if ({fifoCount_o, stall_o} !== 4'b0) begin
        errors++;
        $display("[TB] FAIL reset_count: got count=%0d stall=%b, expected 0/0", fifoCount_o, stall_o);
      end
    end
    reset_i = 1'b0;
    idle();
    step();
  endtask

  task automatic test_single_bypass();
    drive(3'd0, 1'b1, 5'd3, 64'h1234, 1'b1, 5'd7, 64'h9999, 1'b0, 32'd0);
    step();
    idle();
    checks++;
    if ({gprWriteEnable_o, gprWriteAddress_o, gprWriteVal_o} !== {1'b1, 5'd3, 64'h1234}) begin
      errors++;
      $display("[TB] FAIL bypass_write: got we=%b addr=%0d val=%h, expected 1/3/1234",
               gprWriteEnable_o, gprWriteAddress_o, gprWriteVal_o);
    end
    checks++;
    if (fifoCount_o !== 3'd0) begin
      errors++;
      $display("[TB] FAIL bypass_count: got %0d, expected 0", fifoCount_o);
    end
    step();
    checks++;
    if ({gprWriteEnable_o, gprWriteAddress_o, fifoCount_o} !== {1'b0, 5'd3, 3'd0}) begin
      errors++;
      $display("[TB] FAIL bypass_idle: got we=%b addr=%0d count=%0d, expected 0/3/0",
               gprWriteEnable_o, gprWriteAddress_o, fifoCount_o);
    end
  endtask

  task automatic test_dual_order();
    drive(3'd2, 1'b1, 5'd5, 64'hAA, 1'b1, 5'd5, 64'hBB, 1'b0, 32'd0);
    step();
    idle();
    checks++;
    if ({gprWriteEnable_o, gprWriteAddress_o, gprWriteVal_o, fifoCount_o} !== {1'b1, 5'd5, 64'hAA, 3'd1}) begin
      errors++;
      $display("[TB] FAIL dual_first: got we=%b addr=%0d val=%h count=%0d, expected 1/5/aa/1",
               gprWriteEnable_o, gprWriteAddress_o, gprWriteVal_o, fifoCount_o);
    end
    step();
    checks++;
    if ({gprWriteEnable_o, gprWriteAddress_o, gprWriteVal_o, fifoCount_o} !== {1'b1, 5'd5, 64'hBB, 3'd0}) begin
      errors++;
      $display("[TB] FAIL dual_second: got we=%b addr=%0d val=%h count=%0d, expected 1/5/bb/0",
               gprWriteEnable_o, gprWriteAddress_o, gprWriteVal_o, fifoCount_o);
    end
    step();
    checks++;
    if (gprWriteEnable_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL dual_done: got we=%b, expected 0", gprWriteEnable_o);
    end
  endtask

  task automatic test_fill_stall();
    logic [2:0] exp_count [6] = '{3'd1, 3'd2, 3'd3, 3'd2, 3'd1, 3'd0};
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (stall_o !== (k == 3)) begin
        errors++;
        $display("[TB] FAIL fill_stall_%0d: got stall=%b, expected %b", k, stall_o, (k == 3));
      end
      if (k < 3)
        drive(3'd2, 1'b1, 5'(16 + 2*k), 64'(64'h100 + 2*k),
                    1'b1, 5'(17 + 2*k), 64'(64'h101 + 2*k), 1'b0, 32'd0);
      else
        idle();
      step();
      checks++;
      if ({gprWriteEnable_o, gprWriteAddress_o, gprWriteVal_o, fifoCount_o}
          !== {1'b1, 5'(16 + k), 64'(64'h100 + k), exp_count[k]}) begin
        errors++;
        $display("[TB] FAIL fill_drain_%0d: got we=%b addr=%0d val=%h count=%0d, expected 1/%0d/%h/%0d",
                 k, gprWriteEnable_o, gprWriteAddress_o, gprWriteVal_o, fifoCount_o,
                 16 + k, 64'h100 + k, exp_count[k]);
      end
    end
    step();
    checks++;
    if ({gprWriteEnable_o, fifoCount_o, stall_o} !== {1'b0, 3'd0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL fill_empty: got we=%b count=%0d stall=%b, expected 0/0/0",
               gprWriteEnable_o, fifoCount_o, stall_o);
    end
  endtask

  task automatic test_overflow();
    fill_three(5'd0, 64'h500);
    checks++;
    if ({fifoCount_o, stall_o} !== {3'd3, 1'b1}) begin
      errors++;
      $display("[TB] FAIL ovf_precount: got count=%0d stall=%b, expected 3/1", fifoCount_o, stall_o);
    end
    drive(3'd2, 1'b1, 5'd30, 64'hDEAD, 1'b1, 5'd31, 64'hBEEF, 1'b1, 32'hDEADBEEF);
    step();
    idle();
    checks++;
    if ({overflow_o, fifoCount_o, condReg_o} !== {1'b1, 3'd2, 32'hDEADBEEF}) begin
      errors++;
      $display("[TB] FAIL ovf_drop: got ovf=%b count=%0d cr=%h, expected 1/2/deadbeef",
               overflow_o, fifoCount_o, condReg_o);
    end
    checks++;
    if ({gprWriteEnable_o, gprWriteAddress_o, gprWriteVal_o} !== {1'b1, 5'd3, 64'h503}) begin
      errors++;
      $display("[TB] FAIL ovf_head: got we=%b addr=%0d val=%h, expected 1/3/503",
               gprWriteEnable_o, gprWriteAddress_o, gprWriteVal_o);
    end
    for (int k = 4; k < 6; k++) begin
      step();
      checks++;
      if ({overflow_o, gprWriteEnable_o, gprWriteAddress_o, gprWriteVal_o}
          !== {1'b0, 1'b1, 5'(k), 64'(64'h500 + k)}) begin
        errors++;
        $display("[TB] FAIL ovf_drain_%0d: got ovf=%b we=%b addr=%0d val=%h, expected 0/1/%0d/%h",
                 k, overflow_o, gprWriteEnable_o, gprWriteAddress_o, gprWriteVal_o, k, 64'h500 + k);
      end
    end
    step();
    checks++;
    if ({gprWriteEnable_o, fifoCount_o, condReg_o} !== {1'b0, 3'd0, 32'hDEADBEEF}) begin
      errors++;
      $display("[TB] FAIL ovf_nostale: got we=%b count=%0d cr=%h, expected 0/0/deadbeef",
               gprWriteEnable_o, fifoCount_o, condReg_o);
    end
  endtask

  task automatic test_reset_mid_drain();
    fill_three(5'd8, 64'h700);
    reset_i = 1'b1;
    idle();
    step();
    reset_i = 1'b0;
    checks++;
    if ({gprWriteEnable_o, gprWriteAddress_o, gprWriteVal_o, fifoCount_o, stall_o, condReg_o}
        !== '0) begin
      errors++;
      $display("[TB] FAIL midreset_state: got we=%b addr=%0d val=%h count=%0d stall=%b cr=%h, expected all 0",
               gprWriteEnable_o, gprWriteAddress_o, gprWriteVal_o, fifoCount_o, stall_o, condReg_o);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if ({gprWriteEnable_o, fifoCount_o} !== 4'b0) begin
        errors++;
        $display("[TB] FAIL midreset_stale_%0d: got we=%b count=%0d, expected 0/0",
                 i, gprWriteEnable_o, fifoCount_o);
      end
    end
  endtask

  initial begin
    reset_i = 1'b1;
    idle();
    #1;
    test_reset();
    test_single_bypass();
    test_dual_order();
    test_fill_stall();
    test_overflow();
    test_reset_mid_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
